// File: rtl/conv_pkg.sv
// Shared definitions for the Conv2d streaming blocks: default word format,
// output-map geometry helpers, width helper and the drain FSM state type.
package conv_pkg;

    localparam int CONV_N_DEFAULT = 24;
    localparam int CONV_Q_DEFAULT = 13;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } drain_state_e;

    function automatic int conv_out_h(input int h, input int p);
        return h - 2 + 2 * p;
    endfunction

    function automatic int conv_out_w(input int w, input int p);
        return w - 2 + 2 * p;
    endfunction

    // Bits needed to hold 0..v-1; never below 1 so port ranges stay legal.
    function automatic int clog2_min1(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/conv_pix_counter.sv
// Row-major row/col walker over a ROWS x COLS map with a flat pixel index
// and a last-pixel flag; wraps to (0,0) after the last pixel.
module conv_pix_counter
    import conv_pkg::*;
#(
    parameter int ROWS = 4,
    parameter int COLS = 5,
    localparam int RW = clog2_min1(ROWS),
    localparam int CW = clog2_min1(COLS),
    localparam int IW = clog2_min1(ROWS * COLS)
) (
    input  logic          clk,
    input  logic          global_rst,
    input  logic          clear,
    input  logic          advance,
    output logic [RW-1:0] row,
    output logic [CW-1:0] col,
    output logic [IW-1:0] idx,
    output logic          last_pix
);

    logic row_end;
    logic col_end;

    assign col_end  = (col == CW'(COLS - 1));
    assign row_end  = (row == RW'(ROWS - 1));
    assign last_pix = row_end && col_end;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!global_rst || clear) begin
            row <= '0;
            col <= '0;
            idx <= '0;
        end else if (advance) begin
            if (col_end) begin
                col <= '0;
                row <= row_end ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
            idx <= last_pix ? '0 : idx + 1'b1;
        end
    end

endmodule

// File: rtl/conv_result_drain.sv
// Captures one output channel of the Conv2d result bus and replays it as a
// tagged pixel stream (channel/row/col) with optional ReLU.
module conv_result_drain
    import conv_pkg::*;
#(
    parameter int N     = CONV_N_DEFAULT,
    parameter int Q     = CONV_Q_DEFAULT,
    parameter int H     = 8,
    parameter int W     = 40,
    parameter int P     = 1,
    parameter int OUTCH = 256,
    localparam int OH   = conv_out_h(H, P),
    localparam int OW   = conv_out_w(W, P),
    localparam int CHW  = clog2_min1(OUTCH),
    localparam int RW   = clog2_min1(OH),
    localparam int CW   = clog2_min1(OW)
) (
    input  logic               clk,
    input  logic               global_rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [N*OH*OW-1:0] in_result,
    input  logic               relu_en,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [N-1:0]       out_data,
    output logic [CHW-1:0]     out_ch,
    output logic [RW-1:0]      out_row,
    output logic [CW-1:0]      out_col,
    output logic               out_last_pix,
    output logic               out_last_ch,
    output logic               busy
);

    localparam int NPIX = OH * OW;
    localparam int IW   = clog2_min1(NPIX);

    // Q only describes the word format; this block never rescales.
    if (Q < 0 || Q >= N) begin : g_bad_q
        $error("conv_result_drain: Q must lie in [0, N)");
    end

    drain_state_e     state_q;
    drain_state_e     state_d;
    logic [N*NPIX-1:0] buf_q;
    logic             relu_q;
    logic [N-1:0]     data_q;
    logic [CHW-1:0]   ch_q;
    logic [IW-1:0]    pix_idx;
    logic [IW-1:0]    nxt_idx;
    logic [N-1:0]     nxt_pix;
    logic             last_pix;
    logic             capture;
    logic             beat;

    function automatic logic [N-1:0] apply_relu(input logic [N-1:0] pix, input logic en);
        return (en && pix[N-1]) ? '0 : pix;
    endfunction

    assign capture = in_valid && in_ready;
    assign beat    = out_valid && out_ready;

    // NOTE: every signal driven here gets a default first, so no path through
    // the case can leave one unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = STREAM;
            end
            STREAM: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                if (out_ready && last_pix) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Held at (0,0) while idle so each capture starts a fresh walk.
    conv_pix_counter #(
        .ROWS (OH),
        .COLS (OW)
    ) u_pix_counter (
        .clk        (clk),
        .global_rst (global_rst),
        .clear      (in_ready),
        .advance    (beat),
        .row        (out_row),
        .col        (out_col),
        .idx        (pix_idx),
        .last_pix   (last_pix)
    );

    assign nxt_idx = last_pix ? '0 : pix_idx + 1'b1;
    assign nxt_pix = buf_q[nxt_idx*N +: N];

    always_ff @(posedge clk) begin
        if (!global_rst) begin
            state_q <= IDLE;
            relu_q  <= 1'b0;
            data_q  <= '0;
            ch_q    <= '0;
        end else begin
            state_q <= state_d;
            if (capture) begin
                relu_q <= relu_en;
                data_q <= apply_relu(in_result[N-1:0], relu_en);
            end else if (beat && !last_pix) begin
                data_q <= apply_relu(nxt_pix, relu_q);
            end
            if (beat && last_pix) begin
                ch_q <= (ch_q == CHW'(OUTCH - 1)) ? '0 : ch_q + 1'b1;
            end
        end
    end

    // NOTE: the channel buffer has no reset; it is only ever read after a
    // capture has reloaded it, so clearing it would be wasted wiring.
    always_ff @(posedge clk) begin
        if (capture) buf_q <= in_result;
    end

    assign out_data     = data_q;
    assign out_ch       = ch_q;
    assign out_last_pix = last_pix;
    assign out_last_ch  = (ch_q == CHW'(OUTCH - 1));

endmodule

// File: tb/tb_conv_result_drain.sv
// Scoreboard bench for conv_result_drain on a 4x5 output map, 3 channels.
module tb_conv_result_drain;

    localparam int N     = 24;
    localparam int Q     = 13;
    localparam int H     = 4;
    localparam int W     = 5;
    localparam int P     = 1;
    localparam int OUTCH = 3;
    localparam int OH    = 4;
    localparam int OW    = 5;
    localparam int NPIX  = 20;

    typedef logic [NPIX-1:0][N-1:0] pix_arr_t;

    typedef struct packed {
        logic [N-1:0] data;
        logic [1:0]   ch;
        logic [1:0]   row;
        logic [2:0]   col;
        logic         last_pix;
        logic         last_ch;
    } beat_t;

    logic              clk = 1'b0;
    logic              global_rst = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [N*NPIX-1:0] in_result = '0;
    logic              relu_en = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [N-1:0]      out_data;
    logic [1:0]        out_ch;
    logic [1:0]        out_row;
    logic [2:0]        out_col;
    logic              out_last_pix;
    logic              out_last_ch;
    logic              busy;

    int    passed = 0;
    int    total = 0;
    int    exp_ch = 0;
    beat_t sb[$];
    beat_t mon_got;
    beat_t mon_exp;

    conv_result_drain #(
        .N(N), .Q(Q), .H(H), .W(W), .P(P), .OUTCH(OUTCH)
    ) dut (
        .clk          (clk),
        .global_rst   (global_rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_result    (in_result),
        .relu_en      (relu_en),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_ch       (out_ch),
        .out_row      (out_row),
        .out_col      (out_col),
        .out_last_pix (out_last_pix),
        .out_last_ch  (out_last_ch),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within 200000 time units");
        $fatal(1);
    end

    function automatic beat_t sample_out();
        beat_t b;
        b.data     = out_data;
        b.ch       = out_ch;
        b.row      = out_row;
        b.col      = out_col;
        b.last_pix = out_last_pix;
        b.last_ch  = out_last_ch;
        return b;
    endfunction

    // Every handshake is matched against the oldest expected beat.
    always @(negedge clk) begin
        if (global_rst && out_valid && out_ready) begin
            mon_got = sample_out();
            total++;
            if (sb.size() == 0) begin
                $display("FAIL beat_unexpected: got data=%h ch=%0d row=%0d col=%0d, required no beat",
                         mon_got.data, mon_got.ch, mon_got.row, mon_got.col);
            end else begin
                mon_exp = sb.pop_front();
                if (mon_got !== mon_exp)
                    $display("FAIL beat: got data=%h ch=%0d row=%0d col=%0d lp=%0b lc=%0b, required data=%h ch=%0d row=%0d col=%0d lp=%0b lc=%0b",
                             mon_got.data, mon_got.ch, mon_got.row, mon_got.col, mon_got.last_pix, mon_got.last_ch,
                             mon_exp.data, mon_exp.ch, mon_exp.row, mon_exp.col, mon_exp.last_pix, mon_exp.last_ch);
                else
                    passed++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_channel(input pix_arr_t pix, input logic relu);
        beat_t e;
        for (int k = 0; k < NPIX; k++) begin
            e.data     = (relu && pix[k][N-1]) ? '0 : pix[k];
            e.ch       = 2'(exp_ch);
            e.row      = 2'(k / OW);
            e.col      = 3'(k % OW);
            e.last_pix = (k == NPIX - 1);
            e.last_ch  = (exp_ch == OUTCH - 1);
            sb.push_back(e);
        end
        exp_ch = (exp_ch + 1) % OUTCH;
    endtask

    function automatic pix_arr_t make_ramp(input int base);
        pix_arr_t p;
        for (int k = 0; k < NPIX; k++) p[k] = N'(base + k * 'h100);
        return p;
    endfunction

    function automatic pix_arr_t make_relu_pat();
        pix_arr_t p;
        for (int k = 0; k < NPIX; k++) p[k] = (k % 2 == 0) ? 24'hFFFFF0 : 24'h002000;
        return p;
    endfunction

    task automatic apply_reset();
        global_rst = 1'b0;
        in_valid   = 1'b0;
        step();
        step();
        global_rst = 1'b1;
        sb.delete();
        exp_ch = 0;
    endtask

    // Present a channel, wait (bounded) for in_ready, record expectations, capture.
    task automatic capture(input pix_arr_t pix, input logic relu);
        int n;
        n = 0;
        in_result = pix;
        relu_en   = relu;
        in_valid  = 1'b1;
        while (!in_ready && n < 200) begin
            step();
            n++;
        end
        total++;
        if (!in_ready) $display("FAIL capture_wait: in_ready=%0b after %0d cycles, required 1", in_ready, n);
        else passed++;
        push_channel(pix, relu);
        step();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        out_ready = 1'b1;
        while ((sb.size() != 0 || !in_ready) && n < 500) begin
            step();
            n++;
        end
        total++;
        if (sb.size() != 0 || in_ready !== 1'b1)
            $display("FAIL drain: pending=%0d in_ready=%0b, required pending=0 in_ready=1", sb.size(), in_ready);
        else passed++;
    endtask

    task automatic test_reset();
        global_rst = 1'b0;
        out_ready  = 1'b0;
        in_valid   = 1'b0;
        step();
        step();
        total++;
        if ({in_ready, out_valid, busy} !== 3'b100)
            $display("FAIL reset_flags: in_ready/out_valid/busy=%b, required 100", {in_ready, out_valid, busy});
        else passed++;
        total++;
        if (out_data !== '0) $display("FAIL reset_data: got %h, required 000000", out_data);
        else passed++;
        total++;
        if ({out_row, out_col, out_ch, out_last_pix, out_last_ch} !== 9'b0)
            $display("FAIL reset_tags: row=%0d col=%0d ch=%0d lp=%0b lc=%0b, required all 0",
                     out_row, out_col, out_ch, out_last_pix, out_last_ch);
        else passed++;
        global_rst = 1'b1;
        sb.delete();
        exp_ch = 0;
    endtask

    task automatic test_basic();
        int n;
        apply_reset();
        out_ready = 1'b1;
        capture(make_ramp(0), 1'b0);
        total++;
        if ({out_valid, busy, in_ready} !== 3'b110)
            $display("FAIL basic_first_beat: out_valid/busy/in_ready=%b, required 110", {out_valid, busy, in_ready});
        else passed++;
        n = 0;
        while (!in_ready && n < 100) begin
            step();
            n++;
        end
        total++;
        if (n !== NPIX) $display("FAIL basic_stream_len: got %0d cycles, required %0d", n, NPIX);
        else passed++;
        total++;
        if (out_valid !== 1'b0 || sb.size() != 0)
            $display("FAIL basic_end: out_valid=%0b pending=%0d, required 0 and 0", out_valid, sb.size());
        else passed++;
    endtask

    task automatic test_backpressure();
        int    pat[4] = '{1, 0, 0, 1};
        logic  held;
        beat_t snap;
        out_ready = 1'b0;
        capture(make_ramp(0), 1'b0);
        held = 1'b0;
        snap = '0;
        for (int cyc = 0; cyc < 200 && sb.size() != 0; cyc++) begin
            if (held) begin
                total++;
                if (out_valid !== 1'b1 || sample_out() !== snap)
                    $display("FAIL bp_hold: valid=%0b data=%h row=%0d col=%0d, required valid=1 data=%h row=%0d col=%0d",
                             out_valid, out_data, out_row, out_col, snap.data, snap.row, snap.col);
                else passed++;
            end
            total++;
            if (in_ready !== 1'b0) $display("FAIL bp_in_ready: got %0b mid-stream, required 0", in_ready);
            else passed++;
            out_ready = pat[cyc % 4] != 0;
            held = out_valid && !out_ready;
            snap = sample_out();
            step();
        end
        total++;
        if (sb.size() != 0 || in_ready !== 1'b1)
            $display("FAIL bp_end: pending=%0d in_ready=%0b, required 0 and 1", sb.size(), in_ready);
        else passed++;
        out_ready = 1'b1;
    endtask

    task automatic test_relu();
        out_ready = 1'b1;
        capture(make_relu_pat(), 1'b1);
        repeat (5) step();
        relu_en = 1'b0;
        drain();
        capture(make_relu_pat(), 1'b0);
        drain();
    endtask

    task automatic test_channel_wrap();
        int n;
        pix_arr_t pix;
        apply_reset();
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            pix = make_ramp(c << 16);
            in_result = pix;
            relu_en   = 1'b0;
            in_valid  = 1'b1;
            n = 0;
            while (!in_ready && n < 100) begin
                step();
                n++;
            end
            if (c > 0) begin
                total++;
                if (n !== NPIX || out_valid !== 1'b0)
                    $display("FAIL wrap_bubble: ch%0d gap=%0d out_valid=%0b, required gap=%0d out_valid=0",
                             c, n, out_valid, NPIX);
                else passed++;
            end
            push_channel(pix, 1'b0);
            step();
        end
        in_valid = 1'b0;
        drain();
    endtask

    task automatic test_reset_midstream();
        apply_reset();
        out_ready = 1'b1;
        capture(make_ramp(0), 1'b0);
        drain();
        capture(make_ramp('h10000), 1'b0);
        repeat (7) step();
        global_rst = 1'b0;
        step();
        total++;
        if ({out_valid, in_ready, busy} !== 3'b010 || out_ch !== 2'd0)
            $display("FAIL midrst: out_valid/in_ready/busy=%b ch=%0d, required 010 ch=0",
                     {out_valid, in_ready, busy}, out_ch);
        else passed++;
        global_rst = 1'b1;
        sb.delete();
        exp_ch = 0;
        capture(make_ramp('h20000), 1'b0);
        drain();
    endtask

    task automatic test_capture_during_stream();
        int n;
        pix_arr_t rnd;
        pix_arr_t nxt;
        out_ready = 1'b1;
        capture(make_ramp('h30000), 1'b0);
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 100) begin
            for (int k = 0; k < NPIX; k++) rnd[k] = N'($urandom);
            in_result = rnd;
            step();
            n++;
        end
        nxt = make_ramp('h40000);
        in_result = nxt;
        push_channel(nxt, 1'b0);
        step();
        in_valid = 1'b0;
        drain();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_relu();
        test_channel_wrap();
        test_reset_midstream();
        test_capture_during_stream();
        total++;
        if (sb.size() != 0) $display("FAIL final_queue: %0d beats still pending, required 0", sb.size());
        else passed++;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/conv_result_drain.md
Name: conv_result_drain

Overview:
Output-side counterpart of Conv2d. It captures one output channel's flattened result bus per handshake and serialises it into a pixel stream with valid/ready, plus channel/row/col tags and optional ReLU. Sits between Conv2d and the next-layer buffer or the file-dump/trace path. It replaces bulk dumping of the whole wide bus per output channel.

Parameters:
N, 24, fixed-point word width (Q-format total bits)
Q, 13, fractional bits; informational only, no rescaling done here
H, 8, input map height seen by Conv2d
W, 40, input map width seen by Conv2d
P, 1, Conv2d padding; OH = H-2+2P, OW = W-2+2P
OUTCH, 256, output channels per layer (channel counter wrap value)

Ports:
clk  in  1  clock, all logic on rising edge
global_rst  in  1  synchronous reset, active-low
in_valid  in  1  in_result holds a complete channel result
in_ready  out  1  block can capture a channel
in_result  in  N*OH*OW  Conv2d result bus; pixel (r,c) at bits [N*(r*OW+c) +: N]
relu_en  in  1  clamp negative pixels to 0, sampled at capture
out_valid  out  1  out_data/tags valid
out_ready  in  1  downstream accepts
out_data  out  N  pixel value, two's complement
out_ch  out  clog2(OUTCH)  channel index of pixel
out_row  out  clog2(OH)  pixel row
out_col  out  clog2(OW)  pixel column
out_last_pix  out  1  last pixel of current channel
out_last_ch  out  1  current channel is OUTCH-1
busy  out  1  state != IDLE

Behaviour:
- Reset (global_rst=0 at edge): state IDLE, in_ready=1, out_valid=0, out_data=0, out_row=out_col=out_ch=0, out_last_pix=out_last_ch=0, busy=0. Buffer contents are don't-care. Reset mid-stream discards the buffer and restarts at channel 0.
- States: IDLE -> STREAM on in_valid&in_ready. STREAM -> IDLE on handshake of the last pixel. No other transitions.
- IDLE: in_ready=1. On capture at edge t, latch in_result and relu_en. out_valid=1 at t+1 with pixel (0,0). Capture latency is 1 cycle.
- STREAM: in_ready=0. A handshake is out_valid&out_ready at an edge. On a handshake, advance in row-major order: col++, wrap to 0 at OW-1 with row++.
- Without a handshake, out_data and all tags hold stable; in_result changes are ignored.
- out_last_pix = (row==OH-1 && col==OW-1). out_last_ch = (out_ch==OUTCH-1).
- On the last-pixel handshake: out_valid=0 next cycle, in_ready=1 next cycle. out_ch increments, wrapping OUTCH-1 -> 0. Row and col reset to 0.
- Throughput: OH*OW+1 cycles per channel with out_ready held high (one bubble in IDLE).
- ReLU: if latched relu_en and pixel bit N-1 is 1, out_data=0. Otherwise the pixel passes bit-exact. No saturation and no Q shift.
- out_data is registered, driven from a registered mux index and not combinationally from in_result.

Decomposition:
- Shared package conv_pkg: N, Q defaults; functions for OH/OW from H, W, P; clog2 helper; state enum {IDLE, STREAM}.
- Sub-module conv_pix_counter: row/col counter with advance, clear, last_pix flag. Reused by future weight/activation loaders.

Test Plan:
Params N=24, Q=13, H=4, W=5, P=1 (OH=4, OW=5, 20 pixels), OUTCH=3.
1. Basic capture: reset, pixel k = k*0x000100, in_valid one cycle, out_ready=1 -> out_valid from next cycle for 20 cycles. Values 0x000000..0x001300 row-major; (row,col) (0,0)..(3,4); out_last_pix only on the 20th beat; out_ch=0; then one cycle in_ready=1.
2. Backpressure: same data, out_ready toggling 1,0,0,1 -> each pixel emitted exactly once, held stable while out_ready=0, order unchanged. in_ready stays 0 until the last handshake.
3. ReLU: pixels alternate 0xFFFFF0 (-16/8192) and 0x002000 (1.0), relu_en=1 at capture then dropped to 0 mid-stream -> outputs alternate 0x000000/0x002000 for the whole channel. Same data with relu_en=0 -> 0xFFFFF0 passes unchanged.
4. Channel wrap: capture 4 channels back-to-back -> out_ch 0,1,2,0. out_last_ch=1 only during channel 2. Exactly one idle bubble between channels.
5. Reset mid-stream: global_rst=0 after 7 beats of channel 1 -> next cycle out_valid=0, in_ready=1, out_ch=0. A new capture restarts at (0,0) ch 0.
6. Capture during STREAM: in_valid held high with changing in_result -> ignored until IDLE. The next channel carries in_result present at the IDLE capture edge.
